// File: rtl/imem_pkg.sv
// Constants and types shared by the instruction-memory loader and the fetch stage.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_WORDS  = 1 << IMEM_ADDR_W;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words; emits a one-cycle
// word_valid on the cycle after the fourth byte of each word.
module imem_loader_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        lane_q;
  logic [WORD_W-1:0] sr_q;
  logic              word_valid_q;

  // Bytes shift in from the top so the first byte of a word ends up in bits 7:0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= 2'd0;
      sr_q         <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear) begin
        lane_q <= 2'd0;
      end else if (byte_valid) begin
        sr_q         <= {byte_data, sr_q[WORD_W-1:BYTE_W]};
        lane_q       <= lane_q + 2'd1;
        word_valid_q <= (lane_q == 2'd3);
      end
    end
  end

  assign last_lane  = (lane_q == 2'd3);
  assign word_valid = word_valid_q;
  assign word       = sr_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory and
// holds the CPU in reset until a complete image has been verified.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W        = IMEM_ADDR_W,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MaxLen = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_e             state_q;
  logic [BYTE_W-1:0]  len_lo_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [BYTE_W-1:0]  csum_q;
  logic [ADDR_W-1:0]  word_idx_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               hold_q;

  logic               accept;
  logic               pack_valid;
  logic               pack_clear;
  logic               last_lane;
  logic               word_valid;
  logic [WORD_W-1:0]  word;
  logic [LEN_W-1:0]   len_full;

  assign accept     = in_valid && in_ready_q;
  assign pack_valid = accept && (state_q == StData);
  assign pack_clear = start && !busy_q;
  assign len_full   = {in_data, len_lo_q};

  imem_loader_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .last_lane  (last_lane),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_lo_q    <= '0;
      remaining_q <= '0;
      csum_q      <= '0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= HOLD_AT_RESET;
    end else begin
      // The write of the final word lands during StCsum, so advance independently of state.
      if (word_valid) begin
        word_idx_q <= word_idx_q + 1'b1;
      end
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StLenLo;
            csum_q     <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_lo_q <= in_data;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            remaining_q <= len_full;
            if ({1'b0, len_full} > MaxLen) begin
              state_q    <= StErr;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else if (len_full == '0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            csum_q <= csum_q ^ in_data;
            if (last_lane) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                state_q <= StCsum;
              end
            end
          end
        end
        StCsum: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == csum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = word_valid;
  assign imem_waddr = word_idx_q;
  assign imem_wdata = word;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frames plus hand-written gap, reset and
// full-memory sequences.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(
    .ADDR_W        (AW),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        we_prev = 1'b0;
  int          we_long = 0;

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_addr_q.push_back(32'(imem_waddr));
      wr_data_q.push_back(imem_wdata);
      if (we_prev) we_long++;
    end
    we_prev = imem_we;
  end

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          send_csum;
    logic [7:0]  csum;
    bit          exp_done;
    bit          exp_err;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    bit ok;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      ok = in_ready;
      @(negedge clk);
      if (ok) break;
      t++;
      if (t > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word_gaps(input logic [31:0] w, input int gap_max);
    logic [31:0] ww;
    ww = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(ww[8*k +: 8]);
      idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_waddr"}, 32'(imem_waddr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_hold"}, 32'(cpu_hold), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          bad;

    // Data checksum for the 12345678/DEADBEEF image is 0x2A.
    vecs[0] = '{16'h0002, 2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 8'h2A, 1'b1, 1'b0, 2};
    vecs[1] = '{16'h0002, 2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0, 1'b1, 2};
    vecs[2] = '{16'h0101, 0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[3] = '{16'h0000, 0, 32'h0, 32'h0, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[4] = '{16'h0000, 0, 32'h0, 32'h0, 1'b1, 8'h5A, 1'b0, 1'b1, 0};
    vecs[5] = '{16'h0001, 1, 32'h0102_0304, 32'h0, 1'b1, 8'h04, 1'b1, 1'b0, 1};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    idle(10);
    check_reset_vals("idle");
    chk("idle_writes", 32'(wr_addr_q.size()), 0);

    for (int v = 0; v < 6; v++) begin
      clear_log();
      pulse_start();
      chk("start_busy", 32'(busy), 1);
      chk("start_hold", 32'(cpu_hold), 1);
      chk("start_clears", {30'd0, done, err}, 0);
      send_byte(vecs[v].len[7:0]);
      send_byte(vecs[v].len[15:8]);
      for (int i = 0; i < vecs[v].nw; i++) begin
        w = (i == 0) ? vecs[v].w0 : vecs[v].w1;
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8]);
          if (k == 2) chk("we_early", 32'(imem_we), 0);
          if (k == 3) begin
            chk("we_latency", 32'(imem_we), 1);
            chk("we_addr", 32'(imem_waddr), 32'(i));
            chk("we_data", imem_wdata, w);
          end
        end
      end
      if (vecs[v].send_csum) send_byte(vecs[v].csum);
      idle(3);
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_busy", v), 32'(busy), 0);
      chk($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 0);
      chk($sformatf("v%0d_nwr", v), 32'(wr_addr_q.size()), 32'(vecs[v].exp_nwr));
      for (int i = 0; i < wr_addr_q.size() && i < vecs[v].exp_nwr; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), wr_addr_q[i], 32'(i));
        chk($sformatf("v%0d_data%0d", v, i), wr_data_q[i], (i == 0) ? vecs[v].w0 : vecs[v].w1);
      end
    end

    // Random gaps and a start pulse in the middle of the data phase.
    clear_log();
    pulse_start();
    send_byte(8'h02);
    idle(2);
    send_byte(8'h00);
    send_word_gaps(32'h1234_5678, 3);
    send_byte(8'hEF);
    idle(1);
    pulse_start();
    idle(2);
    send_byte(8'hBE);
    idle(3);
    send_byte(8'hAD);
    send_byte(8'hDE);
    idle(2);
    chk("gap_busy_before_csum", 32'(busy), 1);
    send_byte(8'h2A);
    idle(3);
    chk("gap_done", 32'(done), 1);
    chk("gap_err", 32'(err), 0);
    chk("gap_nwr", 32'(wr_addr_q.size()), 2);
    if (wr_addr_q.size() == 2) begin
      chk("gap_addr0", wr_addr_q[0], 0);
      chk("gap_data0", wr_data_q[0], 32'h1234_5678);
      chk("gap_addr1", wr_addr_q[1], 1);
      chk("gap_data1", wr_data_q[1], 32'hDEAD_BEEF);
    end

    // Reset asserted after two data bytes.
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check_reset_vals("abort_after");
    chk("abort_nwr", 32'(wr_addr_q.size()), 0);

    // Full memory: 256 incrementing words.
    clear_log();
    cs = 8'h00;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      w = 32'h1000_0000 + 32'(i);
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
    send_byte(cs);
    idle(3);
    chk("full_done", 32'(done), 1);
    chk("full_hold", 32'(cpu_hold), 0);
    chk("full_nwr", 32'(wr_addr_q.size()), 256);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== 32'h1000_0000 + 32'(i)) bad++;
    end
    chk("full_contents_bad", 32'(bad), 0);
    if (wr_addr_q.size() > 0) begin
      chk("full_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'd255);
      chk("full_last_data", wr_data_q[wr_data_q.size()-1], 32'h1000_00FF);
    end

    // Restart from DONE.
    clear_log();
    pulse_start();
    chk("restart_done_cleared", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_hold", 32'(cpu_hold), 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(3);
    chk("restart_done", 32'(done), 1);
    chk("restart_nwr", 32'(wr_addr_q.size()), 0);

    chk("we_single_cycle", 32'(we_long), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
